// File: rtl/reg2mem_pkg.sv
// Shared definitions for reg2mem and its instruction sequencer.
package reg2mem_pkg;
  localparam int IW_DEF = 10;
  localparam int DW_DEF = 4;

  // Opcode lives in instruction[9:8]
  localparam logic [1:0] STORE_DATA    = 2'd0;
  localparam logic [1:0] MOVE_TO_MEM   = 2'd1;
  localparam logic [1:0] MOVE_FROM_MEM = 2'd2;
  localparam logic [1:0] LOAD_DATA     = 2'd3;

  // Read of mem[0]: writes nothing, so it is safe to drive between instructions
  localparam logic [IW_DEF-1:0] IDLE_INSTR = 10'b11_0000_0000;

  typedef enum logic [1:0] {IDLE, HOLD, NEXT, DONE} issue_state_e;
endpackage

// File: rtl/instr_issue_if.sv
// Load/control/result bundle between a host and the instr_issue sequencer.
interface instr_issue_if import reg2mem_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int IW    = IW_DEF,
  parameter int DW    = DW_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          load_en;
  logic [IW-1:0] load_instr;
  logic          clear;
  logic          start;
  logic [IW-1:0] instruction;
  logic [DW-1:0] res_in;
  logic [DW-1:0] res_out;
  logic          res_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output load_en, load_instr, clear, start, res_in,
    input  instruction, res_out, res_valid, busy, done, count
  );

  modport slave (
    input  load_en, load_instr, clear, start, res_in,
    output instruction, res_out, res_valid, busy, done, count
  );
endinterface

// File: rtl/instr_buf.sv
// Instruction storage: synchronous write, combinational read, no reset.
module instr_buf #(
  parameter int DEPTH = 8,
  parameter int IW    = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [DEPTH-1:0][IW-1:0] mem;

  // Contents deliberately survive reset and runs so a program can be replayed
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_issue.sv
// Issues a preloaded reg2mem program, holding each instruction for
// HOLD_CYCLES and capturing the result of every LOAD_DATA.
module instr_issue import reg2mem_pkg::*; #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int IW          = IW_DEF,
  parameter int DW          = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_issue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  issue_state_e  state;
  logic [AW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] cur_instr;
  logic          buf_we;

  // Loads only land while idle; start and clear both take priority over a load
  assign buf_we = (state == IDLE) && bus.load_en && !bus.clear && !bus.start &&
                  (bus.count != CW'(DEPTH));

  instr_buf #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (bus.count[AW-1:0]),
    .wdata (bus.load_instr),
    .raddr (ptr),
    .rdata (cur_instr)
  );

  // Sequencer FSM with all outputs registered; instruction trails state by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.instruction <= IW'(IDLE_INSTR);
      bus.res_out     <= '0;
      bus.res_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.count       <= '0;
    end else begin
      bus.res_valid   <= 1'b0;
      bus.done        <= (state == DONE);
      bus.instruction <= (state == HOLD) ? cur_instr : IW'(IDLE_INSTR);
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            ptr      <= '0;
            hold_cnt <= '0;
            state    <= (bus.count != '0) ? HOLD : DONE;
          end else if (bus.clear) begin
            bus.count <= '0;
          end else if (bus.load_en && bus.count != CW'(DEPTH)) begin
            bus.count <= bus.count + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            state    <= NEXT;
            // res_in has settled through reg2mem's read path by the last hold cycle
            if (cur_instr[IW-1 -: 2] == LOAD_DATA) begin
              bus.res_out   <= bus.res_in;
              bus.res_valid <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        NEXT: begin
          if ({1'b0, ptr} == bus.count - CW'(1)) begin
            state <= DONE;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= HOLD;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue with a small behavioural reg2mem + BRAM model.
// Model encoding: [9:8] opcode, [7:4] data or register index, [3:0] address.
module tb_instr_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_issue_if #(.DEPTH(8), .IW(10), .DW(4)) bus ();

  instr_issue #(.DEPTH(8), .HOLD_CYCLES(4), .IW(10), .DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // reg2mem model: latch instruction fields, then read/write memory one edge later
  logic [3:0] mem [16];
  logic [3:0] rf  [16];
  logic [1:0] op_q;
  logic [3:0] dat_q, adr_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 4'h0;
        rf[i]  <= 4'h0;
      end
      op_q       <= 2'd3;
      dat_q      <= 4'h0;
      adr_q      <= 4'h0;
      bus.res_in <= 4'h0;
    end else begin
      op_q       <= bus.instruction[9:8];
      dat_q      <= bus.instruction[7:4];
      adr_q      <= bus.instruction[3:0];
      bus.res_in <= mem[adr_q];
      case (op_q)
        2'd0: mem[adr_q] <= dat_q;
        2'd1: mem[adr_q] <= rf[dat_q];
        2'd2: rf[dat_q]  <= mem[adr_q];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [9:0] v);
    @(negedge clk);
    bus.load_en = 1'b1;
    bus.load_instr = v;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Pulse start, then watch cycles n = 1.. after the start edge until done.
  // stress>0 pokes start/load_en/clear while busy; rst_at>0 resets mid-run.
  task automatic run(input int stress, input int rst_at, input logic [9:0] first,
                     output int dcyc, output int nvalid, output logic [3:0] lastres);
    dcyc = -1;
    nvalid = 0;
    lastres = 4'h0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (stress > 0 && n == stress) begin
        bus.start = 1'b1;
        bus.load_en = 1'b1;
        bus.clear = 1'b1;
        bus.load_instr = 10'h3FF;
      end
      if (stress > 0 && n == stress + 1) begin
        bus.start = 1'b0;
        bus.load_en = 1'b0;
        bus.clear = 1'b0;
      end
      if (n == 1) check("first_instr", 32'(bus.instruction), 32'(first));
      if (bus.res_valid) begin
        nvalid++;
        lastres = bus.res_out;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_instr", 32'(bus.instruction), 32'h300);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_out", 32'(bus.res_out), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        break;
      end
      if (bus.done) begin
        dcyc = n;
        check("busy_at_done", 32'(bus.busy), 32'd0);
        break;
      end
    end
  endtask

  int d, nv;
  logic [3:0] r;

  initial begin
    bus.load_en = 1'b0;
    bus.load_instr = 10'h0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_instr", 32'(bus.instruction), 32'h300);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("reset_res_out", 32'(bus.res_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_instr", 32'(bus.instruction), 32'h300);

    // Empty buffer: done one cycle after start, no result
    run(0, 0, 10'h300, d, nv, r);
    check("empty_done_cyc", 32'(d), 32'd1);
    check("empty_nvalid", 32'(nv), 32'd0);

    // STORE A@3, LOAD@3
    do_load(10'h0A3);
    do_load(10'h303);
    check("count_2", 32'(bus.count), 32'd2);
    run(0, 0, 10'h0A3, d, nv, r);
    check("p1_done_cyc", 32'(d), 32'd11);
    check("p1_nvalid", 32'(nv), 32'd1);
    check("p1_res", 32'(r), 32'hA);

    // STORE 5@2, R1<-mem[2], mem[7]<-R1, LOAD@7
    do_clear();
    do_load(10'h052);
    do_load(10'h212);
    do_load(10'h117);
    do_load(10'h307);
    check("count_4", 32'(bus.count), 32'd4);
    run(0, 0, 10'h052, d, nv, r);
    check("p2_done_cyc", 32'(d), 32'd21);
    check("p2_nvalid", 32'(nv), 32'd1);
    check("p2_res", 32'(r), 32'h5);

    // Saturation at DEPTH, then clear beating load_en
    do_clear();
    for (int i = 0; i < 9; i++) do_load(10'(i));
    check("count_sat", 32'(bus.count), 32'd8);
    @(negedge clk);
    bus.clear = 1'b1;
    bus.load_en = 1'b1;
    bus.load_instr = 10'h0FF;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.load_en = 1'b0;
    check("clear_wins", 32'(bus.count), 32'd0);

    // Controls poked while busy are ignored; second start replays identically
    do_load(10'h0A3);
    do_load(10'h303);
    run(3, 0, 10'h0A3, d, nv, r);
    check("stress_done_cyc", 32'(d), 32'd11);
    check("stress_nvalid", 32'(nv), 32'd1);
    check("stress_res", 32'(r), 32'hA);
    check("stress_count", 32'(bus.count), 32'd2);
    run(0, 0, 10'h0A3, d, nv, r);
    check("replay_done_cyc", 32'(d), 32'd11);
    check("replay_nvalid", 32'(nv), 32'd1);
    check("replay_res", 32'(r), 32'hA);

    // Reset during HOLD of the second instruction
    run(0, 7, 10'h0A3, d, nv, r);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_count", 32'(bus.count), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_instr", 32'(bus.instruction), 32'h300);
    run(0, 0, 10'h300, d, nv, r);
    check("post_rst_done_cyc", 32'(d), 32'd1);
    check("post_rst_nvalid", 32'(nv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_issue.md
# instr_issue

Upstream sequencer for `reg2mem`. Software or a testbench preloads a small buffer of 10-bit reg2mem instructions. On `start`, the block issues them in order on `instruction`, holding each one stable long enough for the register/BRAM path to complete. For every LOAD_DATA instruction it captures the `res` value that comes back and presents it with a one-cycle valid strobe.

## Interface
Parameters:
- `DEPTH`, 8: instruction buffer entries; power of two, 2..16.
- `HOLD_CYCLES`, 4: cycles each instruction is held on `instruction`; minimum 4 for the default no-output-register BRAM.
- `IW`, 10: instruction width.
- `DW`, 4: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `load_en`  in  1  append `load_instr` to the buffer.
- `load_instr`  in  IW  instruction to append.
- `clear`  in  1  empty the buffer.
- `start`  in  1  begin issuing the buffer contents.
- `instruction`  out  IW  registered instruction to `reg2mem`.
- `res_in`  in  DW  `res` from `reg2mem`.
- `res_out`  out  DW  captured LOAD_DATA result.
- `res_valid`  out  1  one-cycle strobe; `res_out` is valid in that cycle.
- `busy`  out  1  high from the cycle after `start` until DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `count`  out  $clog2(DEPTH)+1  number of instructions loaded.

## Operation
- Opcode is `instruction[9:8]`: 0 STORE_DATA, 1 MOVE_TO_MEM, 2 MOVE_FROM_MEM, 3 LOAD_DATA.
- IDLE_INSTR = 10'b11_0000_0000, a read of mem[0]. It is harmless because nothing is written. `instruction` carries IDLE_INSTR whenever not in HOLD.
- Load behaviour, in IDLE only:
  - `load_en` writes `buf[count]` and increments `count`.
  - `load_en` with `count == DEPTH` is ignored and `count` saturates.
  - `clear` sets `count` to 0 and does not erase buffer contents.
  - `clear` and `load_en` in the same cycle: `clear` wins.
- FSM states: IDLE, HOLD, NEXT, DONE.
  - IDLE: `start` with `count > 0` goes to HOLD with `ptr` = 0. `start` with `count == 0` goes directly to DONE.
  - HOLD: `instruction = buf[ptr]`. `hold_cnt` counts 0..HOLD_CYCLES-1. At the last count go to NEXT. If the opcode is LOAD_DATA, sample `res_in` into `res_out` in that same cycle and pulse `res_valid` in the NEXT cycle.
  - NEXT: `instruction` = IDLE_INSTR for one cycle, a separation bubble. If `ptr == count-1`, go to DONE; otherwise `ptr++` and go to HOLD.
  - DONE: `done` = 1 for one cycle, then go to IDLE.
- While not in IDLE, `start`, `load_en` and `clear` are ignored.
- The buffer survives a run, so `start` again replays the same program.
- Buffer and pointer arithmetic is unsigned. `ptr` never wraps during a run because the bound is `count`.

## Timing
- Reset values: `instruction` = IDLE_INSTR, `res_out` = 0, `res_valid` = 0, `busy` = 0, `done` = 0, `count` = 0, state IDLE. Buffer contents are not reset.
- Reset asserted mid-run: all outputs return to reset values asynchronously. The in-flight instruction is abandoned, which may leave a partial write in `reg2mem`; this is acceptable.
- All outputs are registered. `start` sampled at edge 0 puts `buf[0]` on `instruction` after edge 1.
- Per-instruction period is HOLD_CYCLES + 1 cycles.
- A run of N instructions ends with `done` N*(HOLD_CYCLES+1)+1 cycles after `start` is sampled.
- `res_in` is sampled at the last HOLD cycle, which is 3 edges after the instruction appears on the default 1-cycle-latency BRAM path: one edge for `reg2mem` to latch `addr`, one for the BRAM read, one for `reg2mem` to register `res`.
- `busy` is 1 in HOLD, NEXT and DONE.

## Structure
- Shared package `reg2mem_pkg` holds the opcode localparams (STORE_DATA, MOVE_TO_MEM, MOVE_FROM_MEM, LOAD_DATA), IDLE_INSTR, and the IW/DW defaults. `reg2mem` should migrate to the same package.
- One sub-module, `instr_buf`: DEPTH x IW register array with a synchronous write port and an asynchronous read port. FSM, counters and result capture live in `instr_issue`.

## Test plan
- Reset then idle: `instruction` = 10'h300, `count` = 0, `busy` = 0; `start` with an empty buffer gives `done` 1 cycle later and no `res_valid`.
- Load {STORE 4'hA@3, LOAD@3}, `start`, with `reg2mem` + BRAM connected: exactly one `res_valid` with `res_out` = 4'hA; `done` at cycle 2*5+1 = 11.
- Load {STORE 4'h5@2, MOVE_FROM_MEM R1<-2, MOVE_TO_MEM R1->7, LOAD@7}: `res_out` = 4'h5.
- Load 9 instructions with DEPTH = 8: `count` = 8; the 9th is ignored. `clear` together with `load_en` gives `count` = 0.
- `start`/`load_en` pulsed while `busy`: no effect on `count` or sequence; a second `start` after `done` replays with identical `res_out` values.
- Deassert `rst_n` during HOLD of the 2nd instruction: outputs go to reset values immediately; after release, state is IDLE and `count` = 0.
